// File: rtl/pipeline_ctrl_if.sv
// Hazard/stall control bundle between the pipeline datapath (master) and pipeline_ctrl (slave).
// dbg_state mirrors the controller FSM (0 RUN, 1 MEM_WAIT, 2 HALT) for checkers.
interface pipeline_ctrl_if;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW, ResultSrcE, PCSrcE;
  // Memory handshake: an access is pending while MemReqM is high and completes in the
  // first cycle that MemReadyM is high; MemReqM must stay high until that cycle.
  logic        MemReqM, MemReadyM;
  logic        StallF, StallD, StallE, StallM;
  logic        FlushD, FlushE, FlushW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        MemErr, Halted;
  logic [31:0] StallCnt, FlushCnt;
  logic [1:0]  dbg_state;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, MemErr, Halted, StallCnt, FlushCnt, dbg_state
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, MemErr, Halted, StallCnt, FlushCnt, dbg_state
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard unit: forwarding, load-use/branch stalls, memory-wait FSM with timeout halt.
// Define PIPELINE_CTRL_PERF_CNT_EN to build the StallCnt/FlushCnt performance counters.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic         clk,
  input logic         rst,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       mem_err;
  logic       lw_stall, mem_stall;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;
  logic [1:0] fwd_a, fwd_b;

  // Memory stage beats Writeback because it holds the younger value.
  always_comb begin
    fwd_a = 2'b00;
    if (bus.RegWriteM && bus.RdM != 5'd0 && bus.RdM == bus.Rs1E)      fwd_a = 2'b10;
    else if (bus.RegWriteW && bus.RdW != 5'd0 && bus.RdW == bus.Rs1E) fwd_a = 2'b01;
    fwd_b = 2'b00;
    if (bus.RegWriteM && bus.RdM != 5'd0 && bus.RdM == bus.Rs2E)      fwd_b = 2'b10;
    else if (bus.RegWriteW && bus.RdW != 5'd0 && bus.RdW == bus.Rs2E) fwd_b = 2'b01;
  end

  assign lw_stall  = bus.ResultSrcE && (bus.RdE != 5'd0) &&
                     ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));
  assign mem_stall = ((state == RUN) && bus.MemReqM && !bus.MemReadyM) ||
                     ((state == MEM_WAIT) && !bus.MemReadyM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state == MEM_WAIT && state_nxt == HALT) mem_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    stall_f      = 1'b0;
    stall_d      = 1'b0;
    stall_e      = 1'b0;
    stall_m      = 1'b0;
    flush_d      = 1'b0;
    flush_e      = 1'b0;
    flush_w      = 1'b0;

    case (state)
      RUN: begin
        if (bus.MemReqM && !bus.MemReadyM) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd0;
        end
      end
      MEM_WAIT: begin
        if (bus.MemReadyM) begin
          state_nxt = RUN;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
          if (wait_cnt == WAIT_LAST) state_nxt = HALT;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase

    // A held E stage keeps branch/load-use decisions pending until the stall lifts.
    if (mem_stall || state == HALT) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      stall_f = lw_stall && !bus.PCSrcE;
      stall_d = lw_stall && !bus.PCSrcE;
      flush_d = bus.PCSrcE;
      flush_e = bus.PCSrcE || lw_stall;
    end
  end

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (stall_f && state != HALT) stall_cnt <= stall_cnt + 32'd1;
      if (flush_d)                  flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign bus.StallCnt = stall_cnt;
  assign bus.FlushCnt = flush_cnt;
`else
  assign bus.StallCnt = 32'd0;
  assign bus.FlushCnt = 32'd0;
`endif

  assign bus.StallF    = stall_f;
  assign bus.StallD    = stall_d;
  assign bus.StallE    = stall_e;
  assign bus.StallM    = stall_m;
  assign bus.FlushD    = flush_d;
  assign bus.FlushE    = flush_e;
  assign bus.FlushW    = flush_w;
  assign bus.ForwardAE = fwd_a;
  assign bus.ForwardBE = fwd_b;
  assign bus.MemErr    = mem_err;
  assign bus.Halted    = (state == HALT);
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: dut_a uses TIMEOUT=16, dut_b uses TIMEOUT=4.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_if a ();
  pipeline_ctrl_if b ();

  pipeline_ctrl #(.TIMEOUT(16)) dut_a (.clk(clk), .rst(rst), .bus(a));
  pipeline_ctrl #(.TIMEOUT(4))  dut_b (.clk(clk), .rst(rst), .bus(b));

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic clear_a();
    a.Rs1D = 5'd0; a.Rs2D = 5'd0; a.Rs1E = 5'd0; a.Rs2E = 5'd0;
    a.RdE = 5'd0; a.RdM = 5'd0; a.RdW = 5'd0;
    a.RegWriteM = 1'b0; a.RegWriteW = 1'b0; a.ResultSrcE = 1'b0;
    a.PCSrcE = 1'b0; a.MemReqM = 1'b0; a.MemReadyM = 1'b0;
  endtask

  task automatic clear_b();
    b.Rs1D = 5'd0; b.Rs2D = 5'd0; b.Rs1E = 5'd0; b.Rs2E = 5'd0;
    b.RdE = 5'd0; b.RdM = 5'd0; b.RdW = 5'd0;
    b.RegWriteM = 1'b0; b.RegWriteW = 1'b0; b.ResultSrcE = 1'b0;
    b.PCSrcE = 1'b0; b.MemReqM = 1'b0; b.MemReadyM = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_a();
    clear_b();
    #1;
    checks++;
    if ({a.StallF, a.StallD, a.StallE, a.StallM, a.FlushD, a.FlushE, a.FlushW} !== 7'b0) begin
      errors++; $display("FAIL reset_ctl got %b want 0000000",
        {a.StallF, a.StallD, a.StallE, a.StallM, a.FlushD, a.FlushE, a.FlushW});
    end
    checks++;
    if ({a.Halted, a.MemErr, a.dbg_state, a.ForwardAE, a.ForwardBE} !== 8'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000000",
        {a.Halted, a.MemErr, a.dbg_state, a.ForwardAE, a.ForwardBE});
    end
    checks++;
    if (a.StallCnt !== 32'd0 || a.FlushCnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt got %0h/%0h want 0/0", a.StallCnt, a.FlushCnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    a.RdM = 5'd5; a.RegWriteM = 1'b1; a.RdW = 5'd5; a.RegWriteW = 1'b1; a.Rs1E = 5'd5;
    #1;
    checks++;
    if (a.ForwardAE !== 2'b10) begin
      errors++; $display("FAIL fwd_a_mem got %b want 10", a.ForwardAE);
    end
    a.RdM = 5'd0;
    #1;
    checks++;
    if (a.ForwardAE !== 2'b01) begin
      errors++; $display("FAIL fwd_a_wb got %b want 01", a.ForwardAE);
    end
    a.RegWriteW = 1'b0;
    #1;
    checks++;
    if (a.ForwardAE !== 2'b00) begin
      errors++; $display("FAIL fwd_a_none got %b want 00", a.ForwardAE);
    end
    a.RdW = 5'd9; a.RegWriteW = 1'b1; a.Rs2E = 5'd9; a.RdM = 5'd3; a.RegWriteM = 1'b1;
    #1;
    checks++;
    if ({a.ForwardAE, a.ForwardBE} !== 4'b0001) begin
      errors++; $display("FAIL fwd_b_wb got %b want 0001", {a.ForwardAE, a.ForwardBE});
    end
    a.Rs2E = 5'd3;
    #1;
    checks++;
    if (a.ForwardBE !== 2'b10) begin
      errors++; $display("FAIL fwd_b_mem got %b want 10", a.ForwardBE);
    end
    a.RdM = 5'd0; a.RdW = 5'd0; a.Rs2E = 5'd0;
    #1;
    checks++;
    if (a.ForwardBE !== 2'b00) begin
      errors++; $display("FAIL fwd_b_x0 got %b want 00", a.ForwardBE);
    end
    clear_a();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    a.ResultSrcE = 1'b1; a.RdE = 5'd7; a.Rs2D = 5'd7; a.PCSrcE = 1'b0;
    #1;
    checks++;
    if ({a.StallF, a.StallD, a.FlushD, a.FlushE, a.StallE} !== 5'b11010) begin
      errors++; $display("FAIL lw_stall got %b want 11010",
        {a.StallF, a.StallD, a.FlushD, a.FlushE, a.StallE});
    end
    a.PCSrcE = 1'b1;
    #1;
    checks++;
    if ({a.StallF, a.StallD, a.FlushD, a.FlushE} !== 4'b0011) begin
      errors++; $display("FAIL lw_branch got %b want 0011",
        {a.StallF, a.StallD, a.FlushD, a.FlushE});
    end
    a.PCSrcE = 1'b0; a.RdE = 5'd0; a.Rs2D = 5'd0;
    #1;
    checks++;
    if ({a.StallF, a.FlushE} !== 2'b00) begin
      errors++; $display("FAIL lw_x0 got %b want 00", {a.StallF, a.FlushE});
    end
    clear_a();
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a.MemReqM = 1'b1; a.MemReadyM = 1'b0;
      #1;
      checks++;
      if ({a.StallF, a.StallD, a.StallE, a.StallM, a.FlushW} !== 5'b11111) begin
        errors++; $display("FAIL mem_stall cyc%0d got %b want 11111", i,
          {a.StallF, a.StallD, a.StallE, a.StallM, a.FlushW});
      end
    end
    @(negedge clk);
    a.MemReadyM = 1'b1;
    #1;
    checks++;
    if ({a.StallF, a.StallD, a.StallE, a.StallM, a.FlushW, a.FlushD, a.FlushE} !== 7'b0) begin
      errors++; $display("FAIL mem_ready got %b want 0000000",
        {a.StallF, a.StallD, a.StallE, a.StallM, a.FlushW, a.FlushD, a.FlushE});
    end
    @(negedge clk);
    clear_a();
    #1;
    checks++;
    if (a.dbg_state !== 2'd0 || a.Halted !== 1'b0) begin
      errors++; $display("FAIL mem_back_run got %0d/%b want 0/0", a.dbg_state, a.Halted);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b.MemReqM = 1'b1; b.MemReadyM = 1'b0;
      #1;
      checks++;
      if ({b.StallF, b.StallM, b.FlushW, b.Halted, b.MemErr} !== 5'b11100) begin
        errors++; $display("FAIL to_stall cyc%0d got %b want 11100", i,
          {b.StallF, b.StallM, b.FlushW, b.Halted, b.MemErr});
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({b.Halted, b.MemErr, b.dbg_state} !== 4'b1110) begin
      errors++; $display("FAIL to_halt got %b want 1110", {b.Halted, b.MemErr, b.dbg_state});
    end
    b.MemReadyM = 1'b1; b.PCSrcE = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({b.StallF, b.StallD, b.StallE, b.StallM, b.FlushW, b.FlushD, b.FlushE, b.Halted, b.MemErr}
        !== 9'b111110011) begin
      errors++; $display("FAIL halt_hold got %b want 111110011",
        {b.StallF, b.StallD, b.StallE, b.StallM, b.FlushW, b.FlushD, b.FlushE, b.Halted, b.MemErr});
    end
    clear_b();
    pulse_rst();
    #1;
    checks++;
    if ({b.StallF, b.StallD, b.StallE, b.StallM, b.FlushW, b.FlushD, b.FlushE,
         b.Halted, b.MemErr, b.dbg_state} !== 11'b0) begin
      errors++; $display("FAIL halt_rst got %b want 00000000000",
        {b.StallF, b.StallD, b.StallE, b.StallM, b.FlushW, b.FlushD, b.FlushE,
         b.Halted, b.MemErr, b.dbg_state});
    end
  endtask

  task automatic test_branch_during_stall();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a.MemReqM = 1'b1; a.MemReadyM = 1'b0; a.PCSrcE = 1'b1;
      a.ResultSrcE = 1'b1; a.RdE = 5'd4; a.Rs1D = 5'd4;
      #1;
      checks++;
      if ({a.FlushD, a.FlushE, a.StallF} !== 3'b001) begin
        errors++; $display("FAIL br_stalled cyc%0d got %b want 001", i,
          {a.FlushD, a.FlushE, a.StallF});
      end
    end
    @(negedge clk);
    a.MemReadyM = 1'b1;
    #1;
    checks++;
    if ({a.FlushD, a.FlushE, a.StallF, a.StallE} !== 4'b1100) begin
      errors++; $display("FAIL br_release got %b want 1100",
        {a.FlushD, a.FlushE, a.StallF, a.StallE});
    end
    @(negedge clk);
    clear_a();
  endtask

  task automatic test_perf_cnt();
    pulse_rst();
`ifdef PIPELINE_CTRL_PERF_CNT_EN
    dut_a.stall_cnt <= 32'hFFFF_FFFF;
    a.MemReqM = 1'b1; a.MemReadyM = 1'b0;
    @(negedge clk);
    a.MemReadyM = 1'b1;
    #1;
    checks++;
    if (a.StallCnt !== 32'd0) begin
      errors++; $display("FAIL stall_cnt_wrap got %0h want 0", a.StallCnt);
    end
`else
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a.MemReqM = 1'b1; a.MemReadyM = (i == 2); a.PCSrcE = 1'b1;
      #1;
      checks++;
      if (a.StallCnt !== 32'd0 || a.FlushCnt !== 32'd0) begin
        errors++; $display("FAIL cnt_tied cyc%0d got %0h/%0h want 0/0", i, a.StallCnt, a.FlushCnt);
      end
    end
`endif
    @(negedge clk);
    clear_a();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_branch_during_stall();
    test_perf_cnt();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
